// File: rtl/fifo_umbral_if.sv
// rtl/fifo_umbral_if.sv - FIFO data, threshold-config and status bundle
interface fifo_umbral_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
);
  logic                  init;
  logic [ADDR_WIDTH:0]   umbral_alto;
  logic [ADDR_WIDTH:0]   umbral_bajo;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  FifoFull;
  logic                  FifoEmpty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;

  modport master (
    output init, umbral_alto, umbral_bajo, push, data_in, pop,
    input  data_out, valid_out, FifoFull, FifoEmpty, almost_full, almost_empty, fifo_error
  );

  modport slave (
    input  init, umbral_alto, umbral_bajo, push, data_in, pop,
    output data_out, valid_out, FifoFull, FifoEmpty, almost_full, almost_empty, fifo_error
  );
endinterface

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with threshold flags and sticky error
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input logic          clk,
  input logic          reset,
  fifo_umbral_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, alto_q, alto_d, bajo_q, bajo_d;
  logic                  error_q, error_d, valid_q, valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  pop_acc, push_acc;

  // A push on a full FIFO is still accepted when a pop frees the slot this cycle.
  always_comb begin
    pop_acc  = bus.pop && (count_q != '0);
    push_acc = bus.push && ((count_q != FULL_CNT) || pop_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    alto_d   = alto_q;
    bajo_d   = bajo_q;
    error_d  = error_q;
    dout_d   = dout_q;
    valid_d  = pop_acc;
    if (pop_acc) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if ((bus.pop && !pop_acc) || (bus.push && !push_acc)) begin
      error_d = 1'b1;
    end
    if (bus.init) begin
      alto_d = bus.umbral_alto;
      bajo_d = bus.umbral_bajo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      alto_q   <= FULL_CNT - CW'(1);
      bajo_q   <= CW'(1);
      error_q  <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      alto_q   <= alto_d;
      bajo_q   <= bajo_d;
      error_q  <= error_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (!reset && push_acc) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.valid_out    = valid_q;
  assign bus.FifoFull     = (count_q == FULL_CNT);
  assign bus.FifoEmpty    = (count_q == '0);
  assign bus.almost_full  = (count_q >= alto_q);
  assign bus.almost_empty = (count_q <= bajo_q);
  assign bus.fifo_error   = error_q;
endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - directed and random checks of fifo_umbral against a queue model
module tb_fifo_umbral;
  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  int            m_alto = 3;
  int            m_bajo = 1;
  bit            m_err  = 1'b0;
  bit            m_vld  = 1'b0;
  logic [DW-1:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out",     32'(bus.data_out),     32'(m_dout));
    chk("valid_out",    32'(bus.valid_out),    32'(m_vld));
    chk("FifoFull",     32'(bus.FifoFull),     32'(q.size() == DEPTH));
    chk("FifoEmpty",    32'(bus.FifoEmpty),    32'(q.size() == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= m_alto));
    chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= m_bajo));
    chk("fifo_error",   32'(bus.fifo_error),   32'(m_err));
  endtask

  // One clock: drive inputs, advance the reference model, compare just after the edge.
  task automatic step(input bit rst, input bit ini, input int ua, input int ub,
                      input bit ps, input int di, input bit pp);
    bit popok;
    bit pushok;
    logic [DW-1:0] dv;
    dv              = DW'(di);
    reset           = rst;
    bus.init        = ini;
    bus.umbral_alto = (AW+1)'(ua);
    bus.umbral_bajo = (AW+1)'(ub);
    bus.push        = ps;
    bus.data_in     = dv;
    bus.pop         = pp;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_alto = DEPTH - 1;
      m_bajo = 1;
      m_err  = 1'b0;
      m_vld  = 1'b0;
      m_dout = '0;
    end else begin
      popok  = pp && (q.size() > 0);
      pushok = ps && ((q.size() < DEPTH) || popok);
      m_vld  = popok;
      if (popok) m_dout = q.pop_front();
      if (pushok) q.push_back(dv);
      if ((pp && !popok) || (ps && !pushok)) m_err = 1'b1;
      if (ini) begin
        m_alto = ua & 7;
        m_bajo = ub & 7;
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_rst();             step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_idle();            step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_push(input int v); step(0, 0, 0, 0, 1, v, 0); endtask
  task automatic do_pop();             step(0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_both(input int v); step(0, 0, 0, 0, 1, v, 1); endtask

  initial begin
    reset           = 1'b1;
    bus.init        = 1'b0;
    bus.umbral_alto = '0;
    bus.umbral_bajo = '0;
    bus.push        = 1'b0;
    bus.data_in     = '0;
    bus.pop         = 1'b0;

    do_rst();
    do_rst();

    step(0, 1, 3, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) do_push(i);
    for (int i = 0; i < 4; i++) do_pop();
    do_idle();

    for (int i = 1; i <= 4; i++) do_push(i);
    do_push(6'h3F);
    chk("overflow_full_kept", 32'(bus.FifoFull), 32'd1);
    for (int i = 0; i < 4; i++) do_pop();
    do_idle();

    do_rst();
    for (int i = 1; i <= 4; i++) do_push(i + 8);
    do_both(6'h15);
    chk("full_pushpop_noerr", 32'(bus.fifo_error), 32'd0);
    for (int i = 0; i < 4; i++) do_pop();

    do_rst();
    do_pop();
    chk("underflow_err", 32'(bus.fifo_error), 32'd1);
    do_rst();
    do_both(6'h2A);
    chk("empty_pushpop_nobypass", 32'(bus.valid_out), 32'd0);
    do_idle();
    do_pop();
    chk("empty_pushpop_data", 32'(bus.data_out), 32'h2A);

    do_rst();
    for (int i = 0; i < 10; i++) begin
      do_push(i);
      do_pop();
      chk("wrap_order", 32'(bus.data_out), 32'(i));
    end
    do_push(6'h11);
    do_push(6'h12);
    do_rst();
    chk("reset_midstream_empty", 32'(bus.FifoEmpty), 32'd1);

    step(0, 1, 0, 5, 0, 0, 0);
    do_idle();
    chk("alto_zero_af", 32'(bus.almost_full), 32'd1);
    do_rst();

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 3, (r >= 3) && (r < 8), $urandom_range(0, 7), $urandom_range(0, 7),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
